// File: rtl/decode_issue_buffer.sv
// Circular decode/issue buffer: accepts up to WIDTH in-order instructions per cycle
// and presents the WIDTH oldest with register fields extracted, retiring a variable count.
module decode_issue_buffer #(
    parameter int          WIDTH       = 2,
    parameter int          DEPTH       = 8,
    parameter int          PC_W        = 64,
    parameter logic [31:0] ENDSIM_INST = 32'h0000_006b
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           flush_i,
    input  logic [WIDTH-1:0]               in_valid_i,
    input  logic [WIDTH*PC_W-1:0]          in_pc_i,
    input  logic [WIDTH*32-1:0]            in_inst_i,
    output logic                           in_ready_o,
    output logic [WIDTH-1:0]               out_valid_o,
    output logic [WIDTH*PC_W-1:0]          out_pc_o,
    output logic [WIDTH*32-1:0]            out_inst_o,
    output logic [WIDTH*5-1:0]             out_rs1_o,
    output logic [WIDTH*5-1:0]             out_rs2_o,
    output logic [WIDTH*5-1:0]             out_rs3_o,
    output logic [WIDTH*5-1:0]             out_rd_o,
    output logic [WIDTH-1:0]               out_endsim_o,
    input  logic [$clog2(WIDTH+1)-1:0]     issue_cnt_i,
    output logic [$clog2(DEPTH+1)-1:0]     occupancy_o
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);

    logic [PC_W-1:0] r_pc   [DEPTH];
    logic [31:0]     r_inst [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [OW-1:0]   r_count;

    logic            w_ready;
    logic            w_runOn;
    logic [CW-1:0]   w_pushRun;
    logic [CW-1:0]   w_pushN;
    logic [CW-1:0]   w_validCnt;
    logic [CW-1:0]   w_popN;
    logic [WIDTH-1:0] w_valid;
    logic [PW-1:0]   w_wrIdx [WIDTH];
    logic [PW-1:0]   w_rdIdx [WIDTH];

    // Ready depends only on the registered count, keeping issue_cnt_i off this path.
    assign w_ready     = (OW'(DEPTH) - r_count) >= OW'(WIDTH);
    assign in_ready_o  = w_ready;
    assign occupancy_o = r_count;

    always_comb begin
        w_pushRun = '0;
        w_runOn   = 1'b1;
        for (int k = 0; k < WIDTH; k++) begin
            w_runOn = w_runOn & in_valid_i[k];
            if (w_runOn) begin
                w_pushRun = w_pushRun + CW'(1);
            end
        end
    end

    always_comb begin
        w_validCnt = (r_count >= OW'(WIDTH)) ? CW'(WIDTH) : CW'(r_count);
        w_pushN    = (w_ready && !flush_i) ? w_pushRun : '0;
        w_popN     = flush_i ? '0 : ((issue_cnt_i < w_validCnt) ? issue_cnt_i : w_validCnt);
    end

    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            w_wrIdx[i] = r_tail + PW'(i);
            w_rdIdx[i] = r_head + PW'(i);
            w_valid[i] = (OW'(i) < r_count) && !flush_i;
        end
    end

    always_comb begin
        out_valid_o  = w_valid;
        out_pc_o     = '0;
        out_inst_o   = '0;
        out_rs1_o    = '0;
        out_rs2_o    = '0;
        out_rs3_o    = '0;
        out_rd_o     = '0;
        out_endsim_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            out_pc_o[i*PC_W +: PC_W] = r_pc[w_rdIdx[i]];
            out_inst_o[i*32 +: 32]   = r_inst[w_rdIdx[i]];
            out_rs1_o[i*5 +: 5]      = r_inst[w_rdIdx[i]][19:15];
            out_rs2_o[i*5 +: 5]      = r_inst[w_rdIdx[i]][24:20];
            out_rs3_o[i*5 +: 5]      = r_inst[w_rdIdx[i]][31:27];
            out_rd_o[i*5 +: 5]       = r_inst[w_rdIdx[i]][11:7];
            out_endsim_o[i]          = w_valid[i] && (r_inst[w_rdIdx[i]] == ENDSIM_INST);
        end
    end

    // Storage is deliberately left unreset; validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WIDTH; k++) begin
            if (CW'(k) < w_pushN) begin
                r_pc[w_wrIdx[k]]   <= in_pc_i[k*PC_W +: PC_W];
                r_inst[w_wrIdx[k]] <= in_inst_i[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(w_popN);
            r_tail  <= r_tail + PW'(w_pushN);
            r_count <= r_count + OW'(w_pushN) - OW'(w_popN);
        end
    end

endmodule

// File: tb/tb_decode_issue_buffer.sv
// Self-checking bench for decode_issue_buffer: directed scenarios plus random traffic,
// checked by a monitor against a queue-based reference of buffered instructions.
module tb_decode_issue_buffer;

    localparam int          WIDTH  = 2;
    localparam int          DEPTH  = 8;
    localparam int          PC_W   = 64;
    localparam int          CW     = $clog2(WIDTH + 1);
    localparam int          OW     = $clog2(DEPTH + 1);
    localparam logic [31:0] ENDSIM = 32'h0000_006b;

    typedef struct {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } entry_t;

    logic                  clk;
    logic                  rst;
    logic                  flush_i;
    logic [WIDTH-1:0]      in_valid_i;
    logic [WIDTH*PC_W-1:0] in_pc_i;
    logic [WIDTH*32-1:0]   in_inst_i;
    logic                  in_ready_o;
    logic [WIDTH-1:0]      out_valid_o;
    logic [WIDTH*PC_W-1:0] out_pc_o;
    logic [WIDTH*32-1:0]   out_inst_o;
    logic [WIDTH*5-1:0]    out_rs1_o;
    logic [WIDTH*5-1:0]    out_rs2_o;
    logic [WIDTH*5-1:0]    out_rs3_o;
    logic [WIDTH*5-1:0]    out_rd_o;
    logic [WIDTH-1:0]      out_endsim_o;
    logic [CW-1:0]         issue_cnt_i;
    logic [OW-1:0]         occupancy_o;

    entry_t      expQ[$];
    int          checkCount = 0;
    int          passCount  = 0;
    logic [63:0] pcCounter  = 64'h2000;

    decode_issue_buffer #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .PC_W(PC_W), .ENDSIM_INST(ENDSIM)
    ) dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_pc_i(in_pc_i), .in_inst_i(in_inst_i),
        .in_ready_o(in_ready_o), .out_valid_o(out_valid_o),
        .out_pc_o(out_pc_o), .out_inst_o(out_inst_o),
        .out_rs1_o(out_rs1_o), .out_rs2_o(out_rs2_o),
        .out_rs3_o(out_rs3_o), .out_rd_o(out_rd_o),
        .out_endsim_o(out_endsim_o), .issue_cnt_i(issue_cnt_i),
        .occupancy_o(occupancy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input int lane,
                               input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s lane%0d actual=%h required=%h t=%0t",
                     name, lane, actual, expected, $time);
        end
    endtask

    function automatic logic [31:0] randInst();
        return ($urandom_range(0, 5) == 0) ? ENDSIM : $urandom;
    endfunction

    // Reference: a plain FIFO of accepted instructions, updated by the buffer's rules.
    initial begin : refModel
        int sz, vc, popN, pushN;
        forever begin
            @(posedge clk);
            if (rst || flush_i) begin
                expQ.delete();
            end else begin
                sz    = expQ.size();
                vc    = (sz < WIDTH) ? sz : WIDTH;
                popN  = (int'(issue_cnt_i) < vc) ? int'(issue_cnt_i) : vc;
                pushN = 0;
                for (int k = 0; k < WIDTH; k++) begin
                    if (in_valid_i[k] && pushN == k) pushN++;
                end
                for (int k = 0; k < popN; k++) void'(expQ.pop_front());
                if (DEPTH - sz >= WIDTH) begin
                    for (int k = 0; k < pushN; k++) begin
                        expQ.push_back('{pc: in_pc_i[k*PC_W +: PC_W], inst: in_inst_i[k*32 +: 32]});
                    end
                end
            end
        end
    end

    initial begin : monitor
        int     sz;
        logic   expValid;
        entry_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sz = expQ.size();
                checkOutput("in_ready", 0, 64'(in_ready_o), 64'((DEPTH - sz) >= WIDTH));
                checkOutput("occupancy", 0, 64'(occupancy_o), 64'(sz));
                for (int i = 0; i < WIDTH; i++) begin
                    expValid = (i < sz) && !flush_i;
                    checkOutput("out_valid", i, 64'(out_valid_o[i]), 64'(expValid));
                    if (expValid) begin
                        e = expQ[i];
                        checkOutput("pc", i, out_pc_o[i*PC_W +: PC_W], e.pc);
                        checkOutput("inst", i, 64'(out_inst_o[i*32 +: 32]), 64'(e.inst));
                        checkOutput("rs1", i, 64'(out_rs1_o[i*5 +: 5]), 64'(e.inst[19:15]));
                        checkOutput("rs2", i, 64'(out_rs2_o[i*5 +: 5]), 64'(e.inst[24:20]));
                        checkOutput("rs3", i, 64'(out_rs3_o[i*5 +: 5]), 64'(e.inst[31:27]));
                        checkOutput("rd", i, 64'(out_rd_o[i*5 +: 5]), 64'(e.inst[11:7]));
                        checkOutput("endsim", i, 64'(out_endsim_o[i]), 64'(e.inst == ENDSIM));
                    end else begin
                        checkOutput("endsim_idle", i, 64'(out_endsim_o[i]), 64'd0);
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [WIDTH-1:0] valid, input logic [63:0] pcBase,
                                 input logic [WIDTH*32-1:0] insts, input int issue,
                                 input logic flush);
        int vc;
        vc = (expQ.size() < WIDTH) ? expQ.size() : WIDTH;
        assert (flush || issue <= vc) else $error("[TB] issue count over presented lanes");
        in_valid_i  = valid;
        in_inst_i   = insts;
        for (int i = 0; i < WIDTH; i++) in_pc_i[i*PC_W +: PC_W] = pcBase + 64'(4 * i);
        issue_cnt_i = CW'(issue);
        flush_i     = flush;
        @(posedge clk);
        #1;
    endtask

    task automatic resetDut();
        rst         = 1'b1;
        in_valid_i  = '0;
        flush_i     = 1'b0;
        issue_cnt_i = '0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
    endtask

    task automatic randomCycle();
        logic [WIDTH-1:0]    valid;
        logic [WIDTH*32-1:0] insts;
        int n, vc, issue;
        logic flush;
        n     = $urandom_range(0, WIDTH);
        valid = '0;
        for (int k = 0; k < n; k++) valid[k] = 1'b1;
        for (int k = 0; k < WIDTH; k++) insts[k*32 +: 32] = randInst();
        vc    = (expQ.size() < WIDTH) ? expQ.size() : WIDTH;
        issue = $urandom_range(0, vc);
        flush = ($urandom_range(0, 19) == 0);
        applyStimulus(valid, pcCounter, insts, issue, flush);
        pcCounter = pcCounter + 64'(4 * WIDTH);
    endtask

    initial begin : stimulus
        logic [WIDTH*32-1:0] insts;
        in_pc_i   = '0;
        in_inst_i = '0;
        resetDut();
        checkOutput("reset_ready", 0, 64'(in_ready_o), 64'd1);
        checkOutput("reset_valid", 0, 64'(out_valid_o), 64'd0);
        checkOutput("reset_occ", 0, 64'(occupancy_o), 64'd0);
        applyStimulus('0, 64'h0, '0, 0, 1'b0);

        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < WIDTH; k++) insts[k*32 +: 32] = randInst();
            applyStimulus(2'b11, pcCounter, insts, 0, 1'b0);
            pcCounter = pcCounter + 64'd8;
            checkOutput("fill_occ", 0, 64'(occupancy_o), 64'(2 * (p + 1)));
            checkOutput("fill_ready", 0, 64'(in_ready_o), 64'(2 * (p + 1) <= DEPTH - WIDTH));
        end
        applyStimulus(2'b11, 64'hdead_0000, {32'h1111_1111, 32'h2222_2222}, 0, 1'b0);
        checkOutput("held_occ", 0, 64'(occupancy_o), 64'd8);
        repeat (4) applyStimulus('0, 64'h0, '0, 2, 1'b0);
        checkOutput("drain_occ", 0, 64'(occupancy_o), 64'd0);

        applyStimulus(2'b11, 64'h1000, {32'h0000_0013, 32'h0000_0093}, 0, 1'b0);
        applyStimulus(2'b01, 64'h1008, {32'h0, 32'h0000_0113}, 0, 1'b0);
        applyStimulus('0, 64'h0, '0, 1, 1'b0);
        checkOutput("partial_pc0", 0, out_pc_o[0 +: PC_W], 64'h1004);
        checkOutput("partial_pc1", 1, out_pc_o[PC_W +: PC_W], 64'h1008);
        checkOutput("partial_occ", 0, 64'(occupancy_o), 64'd2);
        applyStimulus('0, 64'h0, '0, 2, 1'b0);

        applyStimulus(2'b11, pcCounter, {randInst(), randInst()}, 0, 1'b0);
        pcCounter = pcCounter + 64'd8;
        repeat (20) begin
            applyStimulus(2'b11, pcCounter, {randInst(), randInst()}, 2, 1'b0);
            pcCounter = pcCounter + 64'd8;
        end
        checkOutput("stream_occ", 0, 64'(occupancy_o), 64'd2);
        applyStimulus('0, 64'h0, '0, 2, 1'b0);

        repeat (3) begin
            applyStimulus(2'b11, pcCounter, {randInst(), randInst()}, 0, 1'b0);
            pcCounter = pcCounter + 64'd8;
        end
        checkOutput("preflush_occ", 0, 64'(occupancy_o), 64'd6);
        applyStimulus(2'b11, 64'hbad0_0000, {randInst(), randInst()}, 0, 1'b1);
        checkOutput("flush_occ", 0, 64'(occupancy_o), 64'd0);
        applyStimulus('0, 64'h0, '0, 0, 1'b0);

        applyStimulus(2'b11, 64'h3000, {ENDSIM, 32'h00b5_0533}, 0, 1'b0);
        checkOutput("endsim_vec", 0, 64'(out_endsim_o), 64'b10);
        checkOutput("add_rs1", 0, 64'(out_rs1_o[4:0]), 64'd10);
        checkOutput("add_rs2", 0, 64'(out_rs2_o[4:0]), 64'd11);
        checkOutput("add_rd", 0, 64'(out_rd_o[4:0]), 64'd10);
        applyStimulus('0, 64'h0, '0, 2, 1'b0);

        repeat (400) begin
            if ($urandom_range(0, 99) == 0) resetDut();
            else randomCycle();
        end

        applyStimulus('0, 64'h0, '0, 0, 1'b0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/decode_issue_buffer.md
Name: decode_issue_buffer

Overview:
- Parametrised successor to the fixed two-lane decode stage register.
- Sits between the fetch/instruction queue and operand read.
- Accepts up to WIDTH in-order instructions per cycle into a DEPTH-entry circular buffer and presents up to WIDTH oldest instructions with extracted register fields.
- Retires a variable, in-order count per cycle as reported by the scoreboard (partial issue), so a stalled lane no longer blocks the whole packet.

Parameters:
- WIDTH, 2, lanes in and out (1..4).
- DEPTH, 8, buffer entries; power of two; DEPTH >= 2*WIDTH.
- PC_W, 64, PC width.
- ENDSIM_INST, 32'h0000_006b, encoding flagged as end-of-simulation.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- flush_i  in  1  writeback redirect; discards all buffered and incoming instructions.
- in_valid_i  in  WIDTH  per-lane valid from fetch; bit 0 = oldest.
- in_pc_i  in  WIDTH*PC_W  lane i at [i*PC_W +: PC_W].
- in_inst_i  in  WIDTH*32  lane i at [i*32 +: 32].
- in_ready_o  out  1  buffer can take a full WIDTH packet this cycle.
- out_valid_o  out  WIDTH  lane i holds the i-th oldest buffered instruction.
- out_pc_o  out  WIDTH*PC_W  per-lane PC.
- out_inst_o  out  WIDTH*32  per-lane instruction.
- out_rs1_o, out_rs2_o, out_rs3_o, out_rd_o  out  WIDTH*5 each  inst[19:15], [24:20], [31:27], [11:7].
- out_endsim_o  out  WIDTH  lane instruction == ENDSIM_INST, gated by out_valid_o.
- issue_cnt_i  in  $clog2(WIDTH+1)  number of oldest presented lanes consumed this cycle.
- occupancy_o  out  $clog2(DEPTH+1)  registered entry count.

Behaviour:
- State: head ptr, tail ptr ($clog2(DEPTH) bits, wrap modulo DEPTH), count ($clog2(DEPTH+1) bits), DEPTH x {pc, inst} storage.
- Reset (rst=1 at edge): head=tail=count=0. Storage is not reset.
  - After reset: out_valid_o=0, out_endsim_o=0, occupancy_o=0, in_ready_o=1.
  - Data outputs are don't-care while invalid.
- in_ready_o = (DEPTH - count) >= WIDTH. Derived from registered count only; no combinational path from issue_cnt_i.
- Push:
  - push_n = length of the contiguous run of ones in in_valid_i starting at bit 0.
  - Lanes above the first zero are ignored (bench asserts contiguity).
  - Push only when in_ready_o=1 and flush_i=0.
  - Lane k is written to entry (tail+k) mod DEPTH; tail += push_n.
- Present (combinational from registered state):
  - out_valid_o[i] = (i < count) & !flush_i.
  - Lane i reads entry (head+i) mod DEPTH.
  - Same-cycle pushes are not visible; input-to-output latency is 1 cycle minimum.
- Pop:
  - pop_n = min(issue_cnt_i, number of set out_valid_o bits).
  - An over-count is clipped and flagged by a bench assertion.
  - head += pop_n.
- Count update: count_next = count + push_n - pop_n. Simultaneous push and pop in the same cycle is legal, including when full or empty.
- Full: count > DEPTH-WIDTH deasserts in_ready_o. The fetch packet is held upstream, not dropped.
- Empty: count=0 gives out_valid_o=0. A push while empty appears on the next cycle.
- Wrap-around: both pointers wrap independently. A packet straddling entry DEPTH-1/0 must keep lane order.
- Flush:
  - At the next edge: head=tail=count=0.
  - Same-cycle input is discarded; same-cycle issue_cnt_i is ignored.
  - out_valid_o=0 during the flush cycle.
  - Flush has priority over push/pop. Reset has priority over flush.
- Reset mid-operation: identical to the reset state regardless of prior contents.
- Endsim is evaluated per presented lane; any lane may assert independently.

Test Plan:
- Reset then idle: rst high 2 cycles, release -> in_ready_o=1, out_valid_o=2'b00, occupancy_o=0.
- Fill/full (WIDTH=2, DEPTH=8):
  - 4 packets of 2'b11 with issue_cnt_i=0 -> occupancy 2,4,6,8.
  - in_ready_o=0 once count=8 (already 0 after count reaches 7 >6).
  - 5th packet held; no write.
- Partial issue:
  - 3 instructions with PC 0x1000/0x1004/0x1008 buffered; issue_cnt_i=1.
  - Next cycle lane0 pc=0x1004, lane1 pc=0x1008, occupancy 2.
- Wrap with simultaneous push/pop:
  - Steady stream, in_valid 2'b11 and issue_cnt_i=2 every cycle for 20 cycles.
  - PCs emerge in order through pointer wrap; occupancy constant at 2.
- Flush mid-stream:
  - occupancy 6, flush_i=1 with in_valid_i=2'b11 -> out_valid_o=0 that cycle.
  - Next cycle occupancy 0; the flushed-cycle PCs never appear.
- Endsim/field extraction:
  - Lane1 inst=32'h0000_006b, lane0 inst=32'h00b50533 (add a0,a0,a1).
  - Next cycle out_endsim_o=2'b10; lane0 rs1=10, rs2=11, rd=10.
